ifetch_queue: RTL and testbench

- Instruction-fetch initiator that drives the word-addressed instruction memory port and consumes its combinational read data.
- Each accepted fetch is pushed into a small prefetch FIFO of {pc, instr} pairs, presented to decode with a valid/ready handshake.
- Supports a redirect (branch/jump/trap) that flushes the queue and restarts fetch at a new PC.
- Sits between the instruction memory and the CPU decode stage.

---
 rtl/ifetch_queue.sv | 88 ++++++++
 tb/tb_ifetch_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch initiator with a small prefetch FIFO of {pc, instr} pairs.
// Redirect flushes the queue and restarts fetch at a new word-aligned PC.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [31:0]              iaddr,
  input  logic [31:0]              idata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [31:0]     fpc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [31:0]     redirect_al;
  entry_t          head;

  assign redirect_al = redirect_pc & 32'hFFFF_FFFC;
  assign head        = mem_q[rd_ptr];

  // Handshake: decode never sees an entry in a redirect cycle; a full queue still
  // accepts a fetch when the head leaves in the same cycle.
  assign out_valid = (count != '0) & ~redirect;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect & fetch_en & ((count < CW'(DEPTH)) | pop);

  assign iaddr     = fpc;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign level     = count;

  // Control state: fetch PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      fpc    <= redirect_al;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fpc    <= fpc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr] <= '{pc: fpc, instr: idata};
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases queue the expected PCs,
// a negedge monitor checks every accepted entry against the head of that queue.
module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  level;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_pc;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .iaddr(iaddr), .idata(idata),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .level(level)
  );

  // Memory model: mem[i] = 0x1000_0000 + word index.
  assign idata = 32'h1000_0000 + (iaddr >> 2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every transfer must match the next expected PC and its memory word.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=%h required=none", out_pc);
      end else begin
        exp_pc = sb.pop_front();
        chk("pop_pc", out_pc, exp_pc);
        chk("pop_instr", out_instr, 32'h1000_0000 + (exp_pc >> 2));
      end
    end
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    at_neg();
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // Phase 1: streaming after release
    step();
    reset = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    at_neg();
    chk("valid_release_cycle", 32'(out_valid), 32'd0);
    step();
    at_neg();
    chk("valid_after_release", 32'(out_valid), 32'd1);
    step(); step(); step();
    out_ready = 1'b0;
    chk("sb_empty_p1", 32'(sb.size()), 32'd0);

    // Phase 2: back-pressure fills the queue
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      at_neg();
      chk("fill_level", 32'(level), (k < 4) ? 32'(k) : 32'd4);
      step();
    end
    at_neg();
    chk("full_iaddr", iaddr, 32'h10);
    chk("full_level", 32'(level), 32'd4);
    step();
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    sb.push_back(32'hC); sb.push_back(32'h10);
    out_ready = 1'b1;

    // Phase 3: full queue with simultaneous push and pop
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("full_pp_level", 32'(level), 32'd4);
      chk("full_pp_iaddr", iaddr, 32'h10 + 32'(4 * k));
      step();
    end
    chk("sb_empty_p3", 32'(sb.size()), 32'd0);
    fetch_en = 1'b0;
    sb.push_back(32'h14);
    at_neg();
    chk("drain1_level", 32'(level), 32'd4);
    step();

    // Phase 4: redirect with three stale entries queued
    fetch_en = 1'b1; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    at_neg();
    chk("redir_level_before", 32'(level), 32'd3);
    chk("redir_valid_masked", 32'(out_valid), 32'd0);
    step();
    redirect = 1'b0;
    chk("sb_empty_p4", 32'(sb.size()), 32'd0);
    at_neg();
    chk("redir_level", 32'(level), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_iaddr", iaddr, 32'h100);
    step();
    at_neg();
    chk("redir_first_valid", 32'(out_valid), 32'd1);
    chk("redir_first_pc", out_pc, 32'h100);
    chk("redir_first_instr", out_instr, 32'h1000_0040);
    chk("redir_first_level", 32'(level), 32'd1);
    step();

    // Phase 5: PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; out_ready = 1'b1;
    sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000); sb.push_back(32'h0000_0004);
    step();
    redirect = 1'b0;
    at_neg();
    chk("wrap_iaddr", iaddr, 32'hFFFF_FFF8);
    chk("wrap_valid0", 32'(out_valid), 32'd0);
    step(); step(); step(); step(); step();
    out_ready = 1'b0;
    chk("sb_empty_p5", 32'(sb.size()), 32'd0);
    at_neg();
    chk("wrap_level", 32'(level), 32'd1);
    step(); step();

    // Phase 6: fetch disabled drains the queue
    fetch_en = 1'b0; out_ready = 1'b1;
    sb.push_back(32'h8); sb.push_back(32'hC); sb.push_back(32'h10);
    at_neg();
    chk("drain_level3", 32'(level), 32'd3);
    step(); step(); step();
    at_neg();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_iaddr", iaddr, 32'h14);
    chk("sb_empty_p6", 32'(sb.size()), 32'd0);
    step();
    at_neg();
    chk("drain_iaddr_hold", iaddr, 32'h14);
    chk("drain_level_hold", 32'(level), 32'd0);

    // Mid-stream reset discards queued entries
    fetch_en = 1'b1; out_ready = 1'b0;
    step(); step();
    at_neg();
    chk("pre_reset_level", 32'(level), 32'd2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    at_neg();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_iaddr", iaddr, 32'h0);
    step();
    at_neg();
    chk("midrst_first_valid", 32'(out_valid), 32'd1);
    chk("midrst_first_pc", out_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
